// File: rtl/pe_window_feeder.sv
// Window feeder for a single PE: holds a 3x3 weight set and two ping-pong
// pixel banks, streams (pixel, weight) pairs per window, captures the PE
// result and hands it downstream on a valid/ready port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; buffers freely writable
// S_STREAM | driving one tap per cycle with mode_o high
// S_WAIT   | waiting for the PE end-of-window pulse, down-counting timeout
// S_HOLD   | result presented, waiting for res_ready
// S_FIN    | one-cycle done pulse, then back to idle
module pe_window_feeder #(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_win,
    input  logic              ld_en,
    input  logic [1:0]        ld_sel,
    input  logic [3:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic [DATA_W-1:0] pe_in,
    output logic [DATA_W-1:0] pe_filter,
    output logic              mode_o,
    input  logic [DATA_W-1:0] pe_out_i,
    input  logic              single_count_9_i,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);
    localparam int TAP_W = $clog2(TAPS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT, S_HOLD, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        win_q, win_d;
    logic [7:0]        num_q, num_d;
    // index 0/1 are the pixel banks, index 2 the weights
    logic [DATA_W-1:0] mem_q [3][TAPS];
    logic [DATA_W-1:0] mem_d [3][TAPS];
    logic [DATA_W-1:0] pe_in_q, pe_in_d;
    logic [DATA_W-1:0] pe_filter_q, pe_filter_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              ld_err_q, ld_err_d;
    logic              ld_bad;
    logic              advance;

    // Load port: reject reserved targets, out-of-range taps, and anything the
    // current window may be reading; the write lands in mem_d so a window
    // launched on the same edge already sees it.
    always_comb begin
        mem_d  = mem_q;
        ld_bad = (ld_sel == 2'd3) || (ld_addr > 4'(TAPS - 1)) ||
                 ((state_q != S_IDLE) &&
                  ((ld_sel == 2'd2) || (ld_sel == {1'b0, win_q[0]})));
        ld_err_d = ld_en && ld_bad;
        if (ld_en && !ld_bad) begin
            mem_d[ld_sel][ld_addr[TAP_W-1:0]] = ld_data;
        end
    end

    // Next-state logic plus registered-output computation.
    always_comb begin
        state_d       = state_q;
        tap_d         = tap_q;
        tmr_d         = tmr_q;
        win_d         = win_q;
        num_d         = num_q;
        res_data_d    = res_data_q;
        res_valid_d   = res_valid_q;
        err_timeout_d = err_timeout_q;
        advance       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_timeout_d = 1'b0;
                    num_d         = num_win;
                    win_d         = 8'd0;
                    tap_d         = '0;
                    state_d       = (num_win == 8'd0) ? S_FIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (tap_q == TAP_LAST) begin
                    state_d = S_WAIT;
                    tmr_d   = TMR_LOAD;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_WAIT: begin
                if (single_count_9_i) begin
                    res_data_d  = pe_out_i;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (tmr_q == '0) begin
                    // window dropped; move on as though it had been accepted
                    err_timeout_d = 1'b1;
                    advance       = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            win_d = win_q + 8'd1;
            tap_d = '0;
            state_d = (win_q + 8'd1 == num_q) ? S_FIN : S_STREAM;
        end

        mode_d      = (state_d == S_STREAM);
        pe_in_d     = mode_d ? mem_d[{1'b0, win_d[0]}][tap_d] : '0;
        pe_filter_d = mode_d ? mem_d[2][tap_d] : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
    end

    // State, buffers and all outputs registered; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tap_q         <= '0;
            tmr_q         <= '0;
            win_q         <= '0;
            num_q         <= '0;
            pe_in_q       <= '0;
            pe_filter_q   <= '0;
            mode_q        <= 1'b0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            ld_err_q      <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem_q[b][t] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            tap_q         <= tap_d;
            tmr_q         <= tmr_d;
            win_q         <= win_d;
            num_q         <= num_d;
            pe_in_q       <= pe_in_d;
            pe_filter_q   <= pe_filter_d;
            mode_q        <= mode_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            ld_err_q      <= ld_err_d;
            mem_q         <= mem_d;
        end
    end

    assign pe_in       = pe_in_q;
    assign pe_filter   = pe_filter_q;
    assign mode_o      = mode_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_pe_window_feeder.sv
// Bench for pe_window_feeder: bench-side PE model, shadow copy of the
// buffers, expected-result queue filled at stimulus time and drained by an
// independent monitor on every res_valid/res_ready handshake.
module tb_pe_window_feeder;
    localparam int DATA_W  = 8;
    localparam int TAPS    = 9;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        num_win;
    logic              ld_en;
    logic [1:0]        ld_sel;
    logic [3:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;
    logic [DATA_W-1:0] pe_in;
    logic [DATA_W-1:0] pe_filter;
    logic              mode_o;
    logic [DATA_W-1:0] pe_out_i;
    logic              single_count_9_i;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic              err_timeout;

    always #5 clk = ~clk;

    pe_window_feeder #(.DATA_W(DATA_W), .TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_win(num_win),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err), .pe_in(pe_in), .pe_filter(pe_filter), .mode_o(mode_o),
        .pe_out_i(pe_out_i), .single_count_9_i(single_count_9_i),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sh_pix [2][TAPS];
    logic [7:0] sh_wgt [TAPS];
    bit   pe_en = 1'b1;
    bit   rnd_ready = 1'b0;
    int   done_cnt = 0;
    int   mon_win = 0;

    // PE model state
    logic       pm_prev = 1'b0;
    logic [7:0] pm_acc = '0;
    int         pm_pend = 0;

    // monitor state
    logic       mn_prev = 1'b0;
    int         mn_len = 0;
    bit         mn_abort = 1'b0;
    bit         mn_held = 1'b0;
    logic [7:0] mn_hdata = '0;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [7:0] ref_win(input int w);
        int s = 0;
        for (int t = 0; t < TAPS; t++) s += int'(sh_pix[w % 2][t]) * int'(sh_wgt[t]);
        return 8'(s % 256);
    endfunction

    // PE: accumulate while mode high, pulse two cycles after mode falls
    initial begin
        single_count_9_i = 1'b0;
        pe_out_i = '0;
        forever begin
            @(negedge clk);
            single_count_9_i = 1'b0;
            if (mode_o) pm_acc = pm_prev ? pm_acc + pe_in * pe_filter : pe_in * pe_filter;
            if (pm_pend > 0) begin
                pm_pend--;
                if (pm_pend == 0 && pe_en) begin
                    single_count_9_i = 1'b1;
                    pe_out_i = pm_acc;
                end
            end
            if (!mode_o && pm_prev) pm_pend = 2;
            pm_prev = mode_o;
        end
    end

    // Monitor: tap contents, mode run length, hold stability, scoreboard pop
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mn_abort = 1'b1;
                mn_held = 1'b0;
            end else begin
                if (mode_o) begin
                    if (!mn_prev) begin mn_len = 0; mn_abort = 1'b0; end
                    if (mn_len < TAPS) begin
                        check("tap_pixel", pe_in, sh_pix[mon_win % 2][mn_len]);
                        check("tap_weight", pe_filter, sh_wgt[mn_len]);
                    end
                    mn_len++;
                end else begin
                    check("idle_pe_zero", {pe_in, pe_filter}, 0);
                    if (mn_prev && !mn_abort) begin
                        check("mode_run_len", mn_len, TAPS);
                        mon_win++;
                    end
                end
                if (mn_held) check("hold_valid", res_valid, 1);
                if (res_valid) begin
                    check("stall_mode", mode_o, 0);
                    if (mn_held) check("hold_data", res_data, mn_hdata);
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_result: got %0d, required none", res_data);
                        end else begin
                            check("result", res_data, exp_q.pop_front());
                        end
                        mn_held = 1'b0;
                    end else begin
                        mn_held = 1'b1;
                        mn_hdata = res_data;
                    end
                end else begin
                    mn_held = 1'b0;
                end
                if (done) done_cnt++;
            end
            mn_prev = mode_o;
        end
    end

    // Random downstream backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) res_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [3:0] addr,
                        input logic [7:0] data, input bit exp_err);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        cyc();
        ld_en = 1'b0;
        check("ld_err", ld_err, exp_err);
        if (!exp_err) begin
            if (sel == 2'd2) sh_wgt[addr] = data;
            else sh_pix[sel[0]][addr] = data;
        end
    endtask

    task automatic fill(input logic [1:0] sel, input logic [7:0] val, input bit rnd);
        for (int a = 0; a < TAPS; a++)
            load(sel, 4'(a), rnd ? 8'($urandom_range(0, 255)) : val, 1'b0);
    endtask

    task automatic start_run(input logic [7:0] n);
        mon_win = 0;
        start = 1'b1;
        num_win = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm, input bit noise);
        int c0 = done_cnt;
        int k = 0;
        while (done_cnt == c0 && k < budget) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    load(2'd3, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
                else
                    load(2'($urandom_range(0, 2)), 4'($urandom_range(9, 15)), 8'($urandom), 1'b1);
            end else begin
                cyc();
            end
            k++;
        end
        check(nm, done_cnt - c0, 1);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int c0;
        int k;
        rst = 1'b1; start = 1'b0; num_win = '0; ld_en = 1'b0; ld_sel = '0;
        ld_addr = '0; ld_data = '0; res_ready = 1'b1;
        for (int b = 0; b < 2; b++) for (int t = 0; t < TAPS; t++) sh_pix[b][t] = '0;
        for (int t = 0; t < TAPS; t++) sh_wgt[t] = '0;
        cyc();
        check("reset_outputs", {ld_err, pe_in, pe_filter, mode_o, res_data, res_valid,
                                busy, done, err_timeout}, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // basic window: all 10 -> 900 mod 256
        fill(2'd0, 8'd10, 1'b0);
        fill(2'd2, 8'd10, 1'b0);
        load(2'd3, 4'd0, 8'd1, 1'b1);
        load(2'd0, 4'd9, 8'd1, 1'b1);
        exp_q.push_back(8'd132);
        start_run(8'd1);
        wait_done(60, "basic_done", 1'b0);
        check("basic_sb_empty", exp_q.size(), 0);
        check("basic_no_timeout", err_timeout, 0);

        // ping-pong with loads during window 0
        fill(2'd0, 8'd5, 1'b0);
        fill(2'd1, 8'd2, 1'b0);
        fill(2'd2, 8'd5, 1'b0);
        exp_q.push_back(8'd225);
        exp_q.push_back(8'd90);
        start_run(8'd2);
        load(2'd1, 4'd3, 8'd2, 1'b0);
        load(2'd0, 4'd0, 8'd99, 1'b1);
        load(2'd2, 4'd0, 8'd99, 1'b1);
        load(2'd1, 4'd12, 8'd1, 1'b1);
        wait_done(100, "pingpong_done", 1'b0);
        check("pingpong_sb_empty", exp_q.size(), 0);

        // backpressure: 20-cycle stall on the first result
        exp_q.push_back(8'd225);
        exp_q.push_back(8'd90);
        res_ready = 1'b0;
        start_run(8'd2);
        k = 0;
        while (!res_valid && k < 60) begin cyc(); k++; end
        check("bp_first_valid", res_valid, 1);
        repeat (20) cyc();
        check("bp_still_valid", res_valid, 1);
        check("bp_mode_low", mode_o, 0);
        res_ready = 1'b1;
        cyc();
        check("bp_resume_mode", mode_o, 1);
        wait_done(100, "bp_done", 1'b0);
        check("bp_sb_empty", exp_q.size(), 0);

        // timeout: PE never answers
        pe_en = 1'b0;
        start_run(8'd1);
        k = 0;
        while (!mode_o && k < 10) begin cyc(); k++; end
        while (mode_o && k < 30) begin cyc(); k++; end
        k = 0;
        while (!err_timeout && k < 40) begin cyc(); k++; end
        check("timeout_latency", k, TIMEOUT);
        wait_done(20, "timeout_done", 1'b0);
        check("timeout_sticky", err_timeout, 1);
        pe_en = 1'b1;
        repeat (4) cyc();
        exp_q.push_back(ref_win(0));
        start_run(8'd1);
        check("timeout_cleared", err_timeout, 0);
        wait_done(60, "after_timeout_done", 1'b0);

        // num_win = 0
        start_run(8'd0);
        check("nw0_done", done, 1);
        check("nw0_mode", mode_o, 0);
        cyc();
        check("nw0_done_low", done, 0);
        check("nw0_busy", busy, 0);

        // start while busy is ignored
        exp_q.push_back(ref_win(0));
        start_run(8'd1);
        cyc();
        start = 1'b1; num_win = 8'd3;
        cyc();
        start = 1'b0;
        wait_done(60, "busy_start_done", 1'b0);
        c0 = done_cnt;
        repeat (30) cyc();
        check("busy_start_no_rerun", done_cnt - c0, 0);
        check("busy_start_sb_empty", exp_q.size(), 0);

        // reset at tap 4
        start_run(8'd1);
        repeat (4) cyc();
        check("rst_tap4_mode", mode_o, 1);
        c0 = done_cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mode", mode_o, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        for (int b = 0; b < 2; b++) for (int t = 0; t < TAPS; t++) sh_pix[b][t] = '0;
        for (int t = 0; t < TAPS; t++) sh_wgt[t] = '0;
        repeat (10) cyc();
        check("rst_no_done", done_cnt - c0, 0);
        exp_q.push_back(8'd0);
        fill(2'd2, 8'd7, 1'b0);
        start_run(8'd1);
        wait_done(60, "rst_cleared_done", 1'b0);

        // 255 windows, no wrap
        fill(2'd0, 8'd0, 1'b1);
        fill(2'd1, 8'd0, 1'b1);
        fill(2'd2, 8'd0, 1'b1);
        for (int w = 0; w < 255; w++) exp_q.push_back(ref_win(w));
        start_run(8'd255);
        wait_done(255 * 20, "nw255_done", 1'b0);
        check("nw255_sb_empty", exp_q.size(), 0);

        // randomized runs with backpressure and rejected-write noise
        for (int it = 0; it < 20; it++) begin
            int n;
            fill(2'd0, 8'd0, 1'b1);
            fill(2'd1, 8'd0, 1'b1);
            fill(2'd2, 8'd0, 1'b1);
            n = $urandom_range(1, 5);
            for (int w = 0; w < n; w++) exp_q.push_back(ref_win(w));
            rnd_ready = 1'b1;
            start_run(8'(n));
            wait_done(n * 60, "rand_done", 1'b1);
            rnd_ready = 1'b0;
            res_ready = 1'b1;
            check("rand_sb_empty", exp_q.size(), 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
